oam_dma: RTL

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/ppu_pkg.sv | 16 +
 rtl/oam_dma.sv | 104 ++++++++++
 2 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: OAM DMA state encoding,
// OAMDATA register index and default DMA trigger address.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_e;

  localparam logic [2:0]  OAMDATA_IDX      = 3'd4;
  localparam logic [15:0] DMA_REG_ADDR_DEF = 16'h4014;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: stalls the CPU and copies one page into OAMDATA.
// Define OAM_DMA_ALIGN_EN to add the odd-cycle ALIGN state.
module oam_dma
  import ppu_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
  parameter int          OAM_BYTES    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_WE,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  input  logic [7:0]  dma_data_in,
  output logic        ppu_cs_n,
  output logic [2:0]  ppu_reg_addr,
  output logic        ppu_WE,
  output logic [7:0]  ppu_data_out
);

  localparam logic [8:0] LAST_IDX = 9'(OAM_BYTES - 1);

  dma_state_e state, state_n;
  logic [7:0] page;
  logic [8:0] idx;
  logic       trig;
  logic       inc;

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity <= 1'b0;
    else        parity <= ~parity;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      page  <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      if (trig) begin
        page <= cpu_data_in;
        idx  <= '0;
      end else if (inc) begin
        idx  <= idx + 9'd1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    trig         = 1'b0;
    inc          = 1'b0;
    cpu_rdy      = 1'b0;
    dma_active   = 1'b1;
    dma_rd       = 1'b0;
    ppu_cs_n     = 1'b1;
    ppu_WE       = 1'b0;
    ppu_data_out = '0;
    unique case (state)
      IDLE: begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        if (cpu_WE && cpu_addr == DMA_REG_ADDR) begin
          trig    = 1'b1;
          state_n = HALT;
        end
      end
      HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        // parity has toggled once since the trigger cycle
        state_n = parity ? READ : ALIGN;
`else
        state_n = READ;
`endif
      end
      ALIGN: state_n = READ;
      READ: begin
        dma_rd  = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        ppu_cs_n     = 1'b0;
        ppu_WE       = 1'b1;
        ppu_data_out = dma_data_in;
        inc          = 1'b1;
        state_n      = (idx == LAST_IDX) ? IDLE : READ;
      end
      default: state_n = IDLE;
    endcase
  end

  assign dma_addr     = {page, idx[7:0]};
  assign ppu_reg_addr = OAMDATA_IDX;

endmodule
